layer_sequencer: RTL
====================

Name: layer_sequencer

Overview:
- Sequences one shared neuron datapath (MAC accumulate plus activation, 16 x 8-bit lanes) across all neurons of one fully-connected layer.
- For each neuron it fetches a weight+bias word from the layer weight memory and clears the node accumulator. It then presents activations, weights and bias with a one-cycle ready pulse, waits the node latency and captures the 8-bit result into an output vector.
- Sits between the network-level controller (start/done) and the neuron node instance.

Parameters:
- MAX_NODES, 16, maximum neurons per layer; output vector holds MAX_NODES x 8 bits.
- NODE_LAT, 2, cycles from node_rdy pulse to valid node_res.
- ADDR_W, 4, weight memory address width; must satisfy 2^ADDR_W >= MAX_NODES.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to process a layer; sampled only in IDLE.
- num_nodes  in  5  number of neurons in this layer (0..MAX_NODES); sampled with start.
- act_in  in  128  16 x 8-bit input activations, lane 0 in bits [0:7]; sampled with start.
- wmem_addr  out  ADDR_W  weight memory read address.
- wmem_rd  out  1  weight memory read enable; data returns the next cycle.
- wmem_data  in  136  bits [0:127] are weights (lane-aligned with act_in), bits [128:135] are bias.
- node_clr  out  1  clears the node accumulator.
- node_inA  out  128  activations to node.
- node_inB  out  128  weights to node.
- node_bias  out  8  bias to node.
- node_rdy  out  1  one-cycle accumulate strobe to node.
- node_res  in  8  node result.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the layer is complete.
- out_vec  out  MAX_NODES*8  results; neuron k occupies bits [8k:8k+7].

Behaviour:
- Reset: state IDLE. busy, done, wmem_rd, node_clr and node_rdy are 0. wmem_addr, node_inA, node_inB, node_bias and out_vec are 0. Node index and latency counter are 0.
- Reset asserted mid-layer has the same effect: sequencing is abandoned, out_vec is cleared and no done pulse is issued.
- IDLE: on start=1, latch act_in and num_nodes (clamped to MAX_NODES if larger) and clear out_vec.
  - If the latched count is 0, go to DONE; otherwise go to FETCH with index k=0.
  - start while busy is ignored.
- FETCH (1 cycle): wmem_rd=1, wmem_addr=k, node_clr=1. Go to LOAD.
- LOAD (1 cycle): register wmem_data into node_inB and node_bias, and the latched activations into node_inA. node_rdy=1 in the same cycle as the registered values, so the outputs are driven from these registers combinationally on state==LOAD. Load the counter with NODE_LAT. Go to WAIT.
- WAIT (NODE_LAT cycles): node_inA, node_inB and node_bias are held stable. The counter decrements each cycle; at 1 go to CAPTURE.
- CAPTURE (1 cycle): write node_res into out_vec lane k.
  - If k == count-1, go to DONE; otherwise increment k and go to FETCH.
- DONE (1 cycle): done=1, busy=1. Go to IDLE. out_vec holds its value until the next accepted start or rst.
- Per-neuron cost: 3+NODE_LAT cycles.
- Timing: with start accepted at cycle 0, done is high at cycle N*(3+NODE_LAT)+1. For N=0, done is high at cycle 1.
- node_rdy and node_clr are never high in the same cycle. node_rdy pulses exactly N times per layer.
- Lanes of out_vec at index >= N read 0.
- Widths: the index register is 5 bits; wmem_addr is the index truncated to ADDR_W.

Decomposition:
- Shared package ann_pkg holds:
  - state encoding enum (IDLE, FETCH, LOAD, WAIT, CAPTURE, DONE);
  - LANES=16 and LANE_W=8;
  - WORD_W=136 and BIAS_LSB=128.
- Sub-module seq_lat_counter: loadable down-counter with a terminal flag, width clog2(NODE_LAT+1), used for the WAIT state.
- Everything else stays in one module.

Test Plan:
- Reset check: assert rst for 2 cycles -> all outputs 0, busy=0.
- Full layer: NODE_LAT=2, N=3, memory word k = weights 8'h01 in all lanes with bias k; stub node returns 8'h10+k.
  - Expect done at cycle 16 and node_rdy pulses at cycles 2, 7, 12.
  - Expect wmem_addr 0, 1, 2 in FETCH cycles and out_vec lanes 0..2 = 10, 11, 12 with the remaining lanes 0.
- Empty layer: start with num_nodes=0 -> done at cycle 1, no wmem_rd, no node_rdy, out_vec=0.
- Busy rejection: start asserted again at cycle 5 of an N=3 run -> ignored; exactly 3 node_rdy pulses; done at 16.
- Clamp: num_nodes=20 -> exactly 16 neurons processed, last wmem_addr=15, done at cycle 81.
- Mid-layer reset: rst at cycle 8 of an N=3 run -> next cycle IDLE with outputs 0. No done pulse. A fresh start afterwards completes normally.

Source files
------------

// File: rtl/ann_pkg.sv
// Shared definitions for the layer sequencer.
//   state_t  : sequencer FSM encoding
//   LANES    : number of 8-bit lanes in the neuron datapath
//   LANE_W   : width of one activation / weight / result lane
//   WORD_W   : weight memory word width (weights + bias)
//   BIAS_LSB : first bit of the bias field inside a weight word
package ann_pkg;

    localparam int LANES    = 16;
    localparam int LANE_W   = 8;
    localparam int WORD_W   = 136;
    localparam int BIAS_LSB = 128;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        WAIT,
        CAPTURE,
        DONE
    } state_t;

endpackage

// File: rtl/seq_lat_counter.sv
// Loadable down-counter that times the node latency.
//   clk, rst  : clock and synchronous active-high reset
//   load      : load load_val (takes priority over dec)
//   load_val  : value to load
//   dec       : decrement by one (saturates at zero)
//   terminal  : high while the count equals 1, i.e. the last wait cycle
module seq_lat_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             terminal
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - WIDTH'(1);
        end
    end

    assign terminal = (count_reg == WIDTH'(1));

endmodule

// File: rtl/layer_sequencer.sv
// Runs one shared neuron node over every neuron of a fully-connected layer.
// Per neuron: FETCH (read weight word, clear accumulator), LOAD (present
// operands with a one-cycle node_rdy), WAIT (NODE_LAT cycles), CAPTURE
// (store node_res into lane k of out_vec).
//   start/num_nodes/act_in : layer request, sampled in IDLE only
//   wmem_addr/wmem_rd/wmem_data : weight memory port, one-cycle read latency
//   node_clr/node_inA/node_inB/node_bias/node_rdy/node_res : node interface
//   busy/done : status towards the network controller
//   out_vec   : neuron results, neuron k in bits [8k+7:8k]
module layer_sequencer
    import ann_pkg::*;
#(
    parameter int MAX_NODES = 16,
    parameter int NODE_LAT  = 2,
    parameter int ADDR_W    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [4:0]                num_nodes,
    input  logic [LANES*LANE_W-1:0]   act_in,
    output logic [ADDR_W-1:0]         wmem_addr,
    output logic                      wmem_rd,
    input  logic [WORD_W-1:0]         wmem_data,
    output logic                      node_clr,
    output logic [LANES*LANE_W-1:0]   node_inA,
    output logic [LANES*LANE_W-1:0]   node_inB,
    output logic [LANE_W-1:0]         node_bias,
    output logic                      node_rdy,
    input  logic [LANE_W-1:0]         node_res,
    output logic                      busy,
    output logic                      done,
    output logic [MAX_NODES*8-1:0]    out_vec
);

    localparam int CNT_W = $clog2(NODE_LAT + 1);

    state_t                    state_reg, state_next;
    logic [4:0]                k_reg;
    logic [4:0]                count_reg;
    logic [LANES*LANE_W-1:0]   act_reg;
    logic [LANES*LANE_W-1:0]   ina_reg;
    logic [LANES*LANE_W-1:0]   inb_reg;
    logic [LANE_W-1:0]         bias_reg;
    logic [LANE_W-1:0]         lane_reg [MAX_NODES];
    logic [4:0]                count_next;
    logic                      accept;
    logic                      last_node;
    logic                      lat_done;

    assign count_next = (num_nodes > 5'(MAX_NODES)) ? 5'(MAX_NODES) : num_nodes;
    assign accept     = (state_reg == IDLE) && start;
    assign last_node  = (k_reg == (count_reg - 5'd1));

    seq_lat_counter #(
        .WIDTH (CNT_W)
    ) u_lat (
        .clk      (clk),
        .rst      (rst),
        .load     (state_reg == LOAD),
        .load_val (CNT_W'(NODE_LAT)),
        .dec      (state_reg == WAIT),
        .terminal (lat_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            k_reg     <= '0;
            count_reg <= '0;
            act_reg   <= '0;
            ina_reg   <= '0;
            inb_reg   <= '0;
            bias_reg  <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        act_reg   <= act_in;
                        count_reg <= count_next;
                        k_reg     <= '0;
                    end
                end
                LOAD: begin
                    ina_reg  <= act_reg;
                    inb_reg  <= wmem_data[BIAS_LSB-1:0];
                    bias_reg <= wmem_data[BIAS_LSB +: LANE_W];
                end
                CAPTURE: begin
                    if (!last_node) begin
                        k_reg <= k_reg + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // One result register per lane; cleared on reset and on every accepted
    // start so lanes beyond the current neuron count read zero.
    generate
        for (genvar gi = 0; gi < MAX_NODES; gi++) begin : g_lane
            always_ff @(posedge clk) begin
                if (rst || accept) begin
                    lane_reg[gi] <= '0;
                end else if ((state_reg == CAPTURE) && (k_reg == 5'(gi))) begin
                    lane_reg[gi] <= node_res;
                end
            end
            assign out_vec[gi*8 +: 8] = lane_reg[gi];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = (count_next == 5'd0) ? DONE : FETCH;
            FETCH:   state_next = LOAD;
            LOAD:    state_next = WAIT;
            WAIT:    if (lat_done) state_next = CAPTURE;
            CAPTURE: state_next = last_node ? DONE : FETCH;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Memory data arrives during LOAD, so the operands are passed straight
    // through in that cycle and held from the registers afterwards.
    assign node_inA  = (state_reg == LOAD) ? act_reg : ina_reg;
    assign node_inB  = (state_reg == LOAD) ? wmem_data[BIAS_LSB-1:0] : inb_reg;
    assign node_bias = (state_reg == LOAD) ? wmem_data[BIAS_LSB +: LANE_W] : bias_reg;

    assign wmem_rd   = (state_reg == FETCH);
    assign node_clr  = (state_reg == FETCH);
    assign wmem_addr = (state_reg == FETCH) ? k_reg[ADDR_W-1:0] : '0;
    assign node_rdy  = (state_reg == LOAD);
    assign busy      = (state_reg != IDLE);
    assign done      = (state_reg == DONE);

endmodule
